// File: rtl/change_dispenser_if.sv
// Coin-return handshake bundle: payout request, mechanism ready, coin pulses and status.
interface change_dispenser_if;
    logic       start;
    logic [7:0] amount;
    logic       coin_ready;
    logic       quarter_out;
    logic       dime_out;
    logic       nickel_out;
    logic       penny_out;
    logic       busy;
    logic       done;
    logic [7:0] remaining;
    logic [3:0] coin_count;

    modport slave (
        input  start, amount, coin_ready,
        output quarter_out, dime_out, nickel_out, penny_out,
        output busy, done, remaining, coin_count
    );

    modport master (
        output start, amount, coin_ready,
        input  quarter_out, dime_out, nickel_out, penny_out,
        input  busy, done, remaining, coin_count
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin-return engine: pays an 8-bit cent amount as single-cycle coin pulses,
// largest coin first, paced by the mechanism ready signal and a programmable gap.
//
// state    | meaning
// IDLE     | waiting for start; remaining/coin_count hold last payout
// DISPENSE | issuing one coin per ready edge once the gap has elapsed
// DONE     | one-cycle completion pulse, returns to IDLE
module change_dispenser #(
    parameter int unsigned COIN_GAP = 1
) (
    input  logic               clk,
    input  logic               reset,
    change_dispenser_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        DONE     = 2'd2
    } state_t;

    localparam logic [3:0] GAP_LOAD = 4'(COIN_GAP);

    state_t     state_q, state_d;
    logic [7:0] remaining_q, remaining_d;
    logic [3:0] coin_count_q, coin_count_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic [3:0] coins_q, coins_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] coin_val;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            coin_count_q <= '0;
            gap_cnt_q    <= '0;
            coins_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            coin_count_q <= coin_count_d;
            gap_cnt_q    <= gap_cnt_d;
            coins_q      <= coins_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        coin_count_d = coin_count_q;
        gap_cnt_d    = gap_cnt_q;
        coins_d      = 4'b0000;
        coin_val     = 8'd0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    remaining_d  = bus.amount;
                    coin_count_d = 4'd0;
                    gap_cnt_d    = 4'd0;
                    state_d      = (bus.amount == 8'd0) ? DONE : DISPENSE;
                end
            end
            DISPENSE: begin
                if (bus.coin_ready && (gap_cnt_q == 4'd0)) begin
                    // coins_d bit order: quarter, dime, nickel, penny
                    if (remaining_q >= 8'd25) begin
                        coins_d  = 4'b1000;
                        coin_val = 8'd25;
                    end else if (remaining_q >= 8'd10) begin
                        coins_d  = 4'b0100;
                        coin_val = 8'd10;
                    end else if (remaining_q >= 8'd5) begin
                        coins_d  = 4'b0010;
                        coin_val = 8'd5;
                    end else begin
                        coins_d  = 4'b0001;
                        coin_val = 8'd1;
                    end
                    remaining_d  = remaining_q - coin_val;
                    coin_count_d = coin_count_q + 4'd1;
                    gap_cnt_d    = GAP_LOAD;
                    if (remaining_d == 8'd0) begin
                        state_d = DONE;
                    end
                end else if (gap_cnt_q != 4'd0) begin
                    // gap keeps draining even while the mechanism stalls
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign bus.quarter_out = coins_q[3];
    assign bus.dime_out    = coins_q[2];
    assign bus.nickel_out  = coins_q[1];
    assign bus.penny_out   = coins_q[0];
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.remaining   = remaining_q;
    assign bus.coin_count  = coin_count_q;
endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: one instance with gap 1, one with gap 0.
module tb_change_dispenser;
    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    change_dispenser_if if_g1 ();
    change_dispenser_if if_g0 ();

    change_dispenser #(.COIN_GAP(1)) dut_g1 (.clk(clk), .reset(reset), .bus(if_g1));
    change_dispenser #(.COIN_GAP(0)) dut_g0 (.clk(clk), .reset(reset), .bus(if_g0));

    wire [3:0] coins1 = {if_g1.quarter_out, if_g1.dime_out, if_g1.nickel_out, if_g1.penny_out};
    wire [3:0] coins0 = {if_g0.quarter_out, if_g0.dime_out, if_g0.nickel_out, if_g0.penny_out};

    localparam logic [3:0] Q = 4'b1000;
    localparam logic [3:0] D = 4'b0100;
    localparam logic [3:0] N = 4'b0010;
    localparam logic [3:0] P = 4'b0001;
    localparam logic [3:0] Z = 4'b0000;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // one edge on the gap-1 instance, then compare coins/done/busy
    task automatic cyc1(input string tag, input logic [3:0] c, input logic d, input logic b);
        step();
        check({tag, "_coins"}, 32'(coins1), 32'(c));
        check({tag, "_done"}, 32'(if_g1.done), 32'(d));
        check({tag, "_busy"}, 32'(if_g1.busy), 32'(b));
    endtask

    task automatic start1(input logic [7:0] amt);
        if_g1.amount = amt;
        if_g1.start  = 1'b1;
        step();
        if_g1.start  = 1'b0;
    endtask

    logic [3:0] t41 [7];
    logic [3:0] t249 [5];
    logic [3:0] t7 [5];
    bit         seen_done;

    initial begin
        if_g1.start = 1'b0; if_g1.amount = 8'd0; if_g1.coin_ready = 1'b1;
        if_g0.start = 1'b0; if_g0.amount = 8'd0; if_g0.coin_ready = 1'b1;
        t41  = '{Q, Z, D, Z, N, Z, P};
        t249 = '{Q, Z, Q, Z, Q};
        t7   = '{N, Z, P, Z, P};

        repeat (2) step();
        reset = 1'b0;
        step();
        check("rst_coins1", 32'(coins1), 32'(Z));
        check("rst_coins0", 32'(coins0), 32'(Z));
        check("rst_busy", 32'(if_g1.busy), 32'(0));
        check("rst_done", 32'(if_g1.done), 32'(0));
        check("rst_remaining", 32'(if_g1.remaining), 32'(0));
        check("rst_count", 32'(if_g1.coin_count), 32'(0));

        // 41 cents, gap 1: Q D N P on E1 E3 E5 E7
        start1(8'd41);
        check("a41_e0_busy", 32'(if_g1.busy), 32'(1));
        check("a41_e0_coins", 32'(coins1), 32'(Z));
        check("a41_e0_rem", 32'(if_g1.remaining), 32'(41));
        for (int i = 0; i < 7; i++) cyc1($sformatf("a41_e%0d", i + 1), t41[i], i == 6, 1'b1);
        check("a41_rem", 32'(if_g1.remaining), 32'(0));
        check("a41_count", 32'(if_g1.coin_count), 32'(4));
        cyc1("a41_e8", Z, 1'b0, 1'b0);
        check("a41_hold_count", 32'(if_g1.coin_count), 32'(4));

        // 255 cents, gap 0: ten back-to-back quarters then a nickel
        if_g0.amount = 8'd255;
        if_g0.start  = 1'b1;
        step();
        if_g0.start  = 1'b0;
        check("a255_e0_busy", 32'(if_g0.busy), 32'(1));
        for (int i = 1; i <= 11; i++) begin
            step();
            check($sformatf("a255_e%0d_coins", i), 32'(coins0), 32'((i <= 10) ? Q : N));
            check($sformatf("a255_e%0d_onehot", i), 32'($countones(coins0) <= 1), 32'(1));
            check($sformatf("a255_e%0d_done", i), 32'(if_g0.done), 32'(i == 11));
        end
        check("a255_count", 32'(if_g0.coin_count), 32'(11));
        check("a255_rem", 32'(if_g0.remaining), 32'(0));
        step();
        check("a255_busy_end", 32'(if_g0.busy), 32'(0));

        // zero amount: done straight after E0
        start1(8'd0);
        check("a0_e0_coins", 32'(coins1), 32'(Z));
        check("a0_e0_done", 32'(if_g1.done), 32'(1));
        check("a0_e0_busy", 32'(if_g1.busy), 32'(1));
        check("a0_e0_count", 32'(if_g1.coin_count), 32'(0));
        cyc1("a0_e1", Z, 1'b0, 1'b0);

        // 30 cents with the mechanism stalled for five edges
        if_g1.coin_ready = 1'b0;
        start1(8'd30);
        for (int i = 1; i <= 5; i++) begin
            cyc1($sformatf("a30_stall%0d", i), Z, 1'b0, 1'b1);
            check($sformatf("a30_stall%0d_rem", i), 32'(if_g1.remaining), 32'(30));
        end
        if_g1.coin_ready = 1'b1;
        cyc1("a30_e6", Q, 1'b0, 1'b1);
        check("a30_e6_rem", 32'(if_g1.remaining), 32'(5));
        cyc1("a30_e7", Z, 1'b0, 1'b1);
        cyc1("a30_e8", N, 1'b1, 1'b1);
        check("a30_count", 32'(if_g1.coin_count), 32'(2));
        cyc1("a30_e9", Z, 1'b0, 1'b0);

        // 249 cents, asynchronous reset after the third quarter
        start1(8'd249);
        for (int i = 0; i < 5; i++) cyc1($sformatf("a249_e%0d", i + 1), t249[i], 1'b0, 1'b1);
        check("a249_rem", 32'(if_g1.remaining), 32'(174));
        check("a249_count", 32'(if_g1.coin_count), 32'(3));
        #2 reset = 1'b1;
        #1;
        check("arst_coins", 32'(coins1), 32'(Z));
        check("arst_busy", 32'(if_g1.busy), 32'(0));
        check("arst_done", 32'(if_g1.done), 32'(0));
        check("arst_rem", 32'(if_g1.remaining), 32'(0));
        check("arst_count", 32'(if_g1.coin_count), 32'(0));
        step();
        reset = 1'b0;
        start1(8'd7);
        for (int i = 0; i < 5; i++) cyc1($sformatf("a7_e%0d", i + 1), t7[i], i == 4, 1'b1);
        check("a7_count", 32'(if_g1.coin_count), 32'(3));
        step();

        // 60 cents; a second start during DISPENSE and during DONE is ignored
        start1(8'd60);
        cyc1("a60_e1", Q, 1'b0, 1'b1);
        if_g1.amount = 8'd99;
        if_g1.start  = 1'b1;
        cyc1("a60_e2", Z, 1'b0, 1'b1);
        if_g1.start  = 1'b0;
        check("a60_e2_rem", 32'(if_g1.remaining), 32'(35));
        cyc1("a60_e3", Q, 1'b0, 1'b1);
        cyc1("a60_e4", Z, 1'b0, 1'b1);
        cyc1("a60_e5", D, 1'b1, 1'b1);
        check("a60_count", 32'(if_g1.coin_count), 32'(3));
        if_g1.start = 1'b1;
        cyc1("a60_e6", Z, 1'b0, 1'b0);
        check("a60_done_ignore_rem", 32'(if_g1.remaining), 32'(0));
        check("a60_done_ignore_count", 32'(if_g1.coin_count), 32'(3));
        step();
        if_g1.start = 1'b0;
        check("a99_accept_busy", 32'(if_g1.busy), 32'(1));
        check("a99_accept_rem", 32'(if_g1.remaining), 32'(99));
        seen_done = 1'b0;
        for (int i = 0; i < 40 && !seen_done; i++) begin
            step();
            if (if_g1.done) seen_done = 1'b1;
        end
        check("a99_done_seen", 32'(seen_done), 32'(1));
        check("a99_count", 32'(if_g1.coin_count), 32'(9));
        check("a99_rem", 32'(if_g1.remaining), 32'(0));
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
